// File: rtl/lab1_imul_sched_pkg.sv
// Shared types and widths for the multiplier scheduler.
// Optional build macro honoured by the scheduler top: IMUL_SCHED_ZERO_BYPASS_EN.
package lab1_imul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int MSG_IN_W  = 64;
  localparam int MSG_OUT_W = 32;
  localparam int OPND_W    = 32;

  // True when either operand of a packed {a,b} message is zero.
  function automatic logic opnd_has_zero(input logic [MSG_IN_W-1:0] msg);
    return (msg[MSG_IN_W-1:OPND_W] == '0) || (msg[OPND_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/lab1_imul_rr_arb.sv
// Round-robin arbiter for the multiplier scheduler.
// Search starts at ptr and wraps; ptr is owned here and moves to idx+1
// (wrapping NREQ-1 -> 0) when the scheduler signals completion of an op.
module lab1_imul_rr_arb
  import lab1_imul_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             adv_en,
  input  logic [IDX_W-1:0] adv_idx,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;

  // Pick the first valid requester at or after ptr, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Next pointer: one past the port just served, wrapping at NREQ-1.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_en) begin
      ptr_d = (adv_idx == IDX_W'(NREQ - 1)) ? '0 : adv_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lab1_imul_mul_sched.sv
// Shares one iterative multiplier among NREQ requester streams.
// One op in flight: grant round-robin, push {a,b} into the multiplier,
// return the product to the granted requester only.
// Build macro: IMUL_SCHED_ZERO_BYPASS_EN -- ops with a zero operand skip the
// multiplier and answer 0 the cycle after acceptance.
//
// state | meaning
// IDLE  | arbitrate; Mealy req_rdy to winner, latch id/op on accept
// ISSUE | present op to multiplier until it is taken
// WAIT  | accept product from multiplier
// RESP  | present product to requester id until it is taken
module lab1_imul_mul_sched
  import lab1_imul_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_val,
  output logic [NREQ-1:0]           req_rdy,
  input  logic [NREQ*MSG_IN_W-1:0]  req_msg,
  output logic [NREQ-1:0]           resp_val,
  input  logic [NREQ-1:0]           resp_rdy,
  output logic [NREQ*MSG_OUT_W-1:0] resp_msg,
  output logic                      mul_in_val,
  input  logic                      mul_in_rdy,
  output logic [MSG_IN_W-1:0]       mul_in_msg,
  input  logic                      mul_out_val,
  output logic                      mul_out_rdy,
  input  logic [MSG_OUT_W-1:0]      mul_out_msg
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e          state_q, state_d;
  logic [IDX_W-1:0]      id_q, id_d;
  logic [MSG_IN_W-1:0]   op_q, op_d;
  logic [MSG_OUT_W-1:0]  prod_q, prod_d;

  logic [NREQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  adv_en;
  logic [MSG_IN_W-1:0]   req_slot [NREQ];

  // Unpack the flat request bus into per-port operand pairs.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_slot[i] = req_msg[i*MSG_IN_W +: MSG_IN_W];
    end
  end

  lab1_imul_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_val),
    .adv_en  (adv_en),
    .adv_idx (id_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Scheduler next-state and outputs; everything forced low while in reset.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    op_d        = op_q;
    prod_d      = prod_q;
    adv_en      = 1'b0;
    req_rdy     = '0;
    resp_val    = '0;
    resp_msg    = '0;
    mul_in_val  = 1'b0;
    mul_in_msg  = '0;
    mul_out_rdy = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_rdy = arb_gnt;
          id_d    = arb_idx;
          op_d    = req_slot[arb_idx];
`ifdef IMUL_SCHED_ZERO_BYPASS_EN
          if (opnd_has_zero(req_slot[arb_idx])) begin
            prod_d  = '0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        mul_in_val = 1'b1;
        mul_in_msg = op_q;
        if (mul_in_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        mul_out_rdy = 1'b1;
        if (mul_out_val) begin
          prod_d  = mul_out_msg;
          state_d = RESP;
        end
      end
      RESP: begin
        for (int i = 0; i < NREQ; i++) begin
          if (id_q == IDX_W'(i)) begin
            resp_val[i]                        = 1'b1;
            resp_msg[i*MSG_OUT_W +: MSG_OUT_W] = prod_q;
          end
        end
        if (resp_rdy[id_q]) begin
          adv_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      adv_en      = 1'b0;
      req_rdy     = '0;
      resp_val    = '0;
      resp_msg    = '0;
      mul_in_val  = 1'b0;
      mul_in_msg  = '0;
      mul_out_rdy = 1'b0;
    end
  end

  // State and operand/product latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      op_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_lab1_imul_mul_sched.sv
// Scoreboard bench for lab1_imul_mul_sched with a behavioural variable-latency
// multiplier, per-port sources with random valid delay and random response ready.
module tb_lab1_imul_mul_sched;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_val = '0;
  logic [N-1:0]    req_rdy;
  logic [N*64-1:0] req_msg = '0;
  logic [N-1:0]    resp_val;
  logic [N-1:0]    resp_rdy = '0;
  logic [N*32-1:0] resp_msg;
  logic            mul_in_val, mul_in_rdy, mul_out_val, mul_out_rdy;
  logic [63:0]     mul_in_msg;
  logic [31:0]     mul_out_msg;

  lab1_imul_mul_sched #(.NREQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_in_val(mul_in_val), .mul_in_rdy(mul_in_rdy), .mul_in_msg(mul_in_msg),
    .mul_out_val(mul_out_val), .mul_out_rdy(mul_out_rdy), .mul_out_msg(mul_out_msg)
  );

  // ---------------- behavioural multiplier (shares reset) ----------------
  logic        m_busy, m_done, m_stall;
  int          m_cnt;
  logic [31:0] m_res;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_stall <= 1'b0; m_cnt <= 0; m_res <= '0;
    end else begin
      m_stall <= ($urandom_range(0, 3) == 0);
      if (mul_in_val && mul_in_rdy) begin
        m_busy <= 1'b1;
        m_cnt  <= int'($urandom_range(0, 6));
        m_res  <= mul_in_msg[63:32] * mul_in_msg[31:0];
      end else if (m_busy) begin
        if (m_cnt == 0) begin m_busy <= 1'b0; m_done <= 1'b1; end
        else m_cnt <= m_cnt - 1;
      end else if (m_done && mul_out_rdy) begin
        m_done <= 1'b0;
      end
    end
  end
  assign mul_in_rdy  = !m_busy && !m_done && !m_stall;
  assign mul_out_val = m_done;
  assign mul_out_msg = m_done ? m_res : 32'd0;

  // ---------------- checking infrastructure ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic ok, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          port;
    logic [63:0] op;
    logic [31:0] prod;
    logic        zero;
  } exp_t;

  exp_t        scb[$];
  int          gnt_log[$];
  logic        outstanding = 1'b0;
  int          mptr = 0;
  int          acc_cyc = 0;
  logic        saw_mul_in = 1'b0;
  logic        resp_seen = 1'b0;
  logic [N-1:0] fire_req = '0;
  logic [31:0] last_prod [N];
  int          resp_cnt [N];

  // Expected grant: first valid port scanning from the model pointer.
  function automatic logic [N-1:0] rr_exp(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
    end
    return '0;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [63:0] op);
    longint unsigned pa, pb, pr;
    pa = longint'(op[63:32]);
    pb = longint'(op[31:0]);
    pr = (pa * pb) % 64'h1_0000_0000;
    return pr[31:0];
  endfunction

  exp_t            e_cur;
  exp_t            e_new;
  logic [N-1:0]    exp_rdy;
  logic [N*32-1:0] exp_m;

  // Monitor: samples at the falling edge, pushes on accept, pops on response.
  always @(negedge clk) begin
    cyc++;
    fire_req = '0;
    if (reset) begin
      chk("reset_outputs_zero",
          (req_rdy == '0) && (resp_val == '0) && (resp_msg == '0) &&
          !mul_in_val && (mul_in_msg == '0) && !mul_out_rdy,
          {req_rdy, resp_val, mul_in_val, mul_out_rdy}, 0);
      scb.delete();
      outstanding = 1'b0;
      mptr = 0;
    end else begin
      exp_rdy = outstanding ? '0 : rr_exp(req_val, mptr);
      chk("req_rdy_grant", req_rdy == exp_rdy, req_rdy, exp_rdy);

      if (mul_in_val) begin
        chk("mul_in_only_with_op", outstanding && (scb.size() > 0), outstanding, 1);
        if (scb.size() > 0) chk("mul_in_msg", mul_in_msg == scb[0].op, mul_in_msg, scb[0].op);
        saw_mul_in = 1'b1;
      end
      if (mul_out_rdy) begin
        chk("mul_out_rdy_only_wait",
            outstanding && (resp_val == '0) && !mul_in_val && (req_rdy == '0),
            {resp_val, mul_in_val, req_rdy}, 0);
      end

      if (resp_val != '0) begin
        if (scb.size() == 0) begin
          chk("resp_unexpected", 1'b0, resp_val, 0);
        end else begin
          e_cur = scb[0];
          exp_m = '0;
          exp_m[e_cur.port*32 +: 32] = e_cur.prod;
          chk("resp_val_port", resp_val == (N'(1) << e_cur.port), resp_val, N'(1) << e_cur.port);
          chk("resp_msg", resp_msg == exp_m, resp_msg, exp_m);
          chk("req_rdy_low_in_resp", req_rdy == '0, req_rdy, 0);
          if (!resp_seen) begin
            resp_seen = 1'b1;
`ifdef IMUL_SCHED_ZERO_BYPASS_EN
            if (e_cur.zero) begin
              chk("bypass_latency", (cyc - acc_cyc) == 1, cyc - acc_cyc, 1);
              chk("bypass_mul_untouched", !saw_mul_in, saw_mul_in, 0);
            end else begin
              chk("op_used_mul", saw_mul_in, saw_mul_in, 1);
            end
`else
            chk("op_used_mul", saw_mul_in, saw_mul_in, 1);
`endif
          end
          if (resp_rdy[e_cur.port]) begin
            void'(scb.pop_front());
            outstanding = 1'b0;
            mptr = (e_cur.port + 1) % N;
            last_prod[e_cur.port] = resp_msg[e_cur.port*32 +: 32];
            resp_cnt[e_cur.port]++;
          end
        end
      end else begin
        chk("resp_msg_zero_idle", resp_msg == '0, resp_msg, 0);
      end

      if ((req_rdy & req_val) != '0) begin
        for (int i = 0; i < N; i++) begin
          if (req_rdy[i] && req_val[i]) begin
            e_new.port = i;
            e_new.op   = req_msg[i*64 +: 64];
            e_new.prod = ref_prod(e_new.op);
            e_new.zero = (e_new.op[63:32] == 0) || (e_new.op[31:0] == 0);
            scb.push_back(e_new);
            gnt_log.push_back(i);
            fire_req[i] = 1'b1;
          end
        end
        outstanding = 1'b1;
        acc_cyc = cyc;
        saw_mul_in = 1'b0;
        resp_seen = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0]  src_q [N][$];
  logic         eager = 1'b0;
  logic [N-1:0] hold_lo = '0;

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire_req[i]) begin
        req_val[i] = 1'b0;
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      if (!req_val[i] && src_q[i].size() > 0 && (eager || $urandom_range(0, 2) == 0)) begin
        req_val[i] = 1'b1;
        req_msg[i*64 +: 64] = src_q[i][0];
      end
      resp_rdy[i] = hold_lo[i] ? 1'b0 : (eager ? 1'b1 : ($urandom_range(0, 2) != 0));
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req_val = '0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  function automatic logic busy();
    logic b;
    b = outstanding || (scb.size() > 0) || (req_val != '0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (busy() && t < 3000) begin
      cycle();
      t++;
    end
    chk(nm, t < 3000, t, 3000);
  endtask

  task automatic chk_log(input string nm, input int a0, input int a1);
    chk({nm, "_len"}, gnt_log.size() >= 2, gnt_log.size(), 2);
    if (gnt_log.size() >= 2) begin
      chk({nm, "_first"}, gnt_log[0] == a0, gnt_log[0], a0);
      chk({nm, "_second"}, gnt_log[1] == a1, gnt_log[1], a1);
    end
  endtask

  initial begin
    int t;
    int held;
    int cnt1;
    logic [31:0] a, b;
    for (int i = 0; i < N; i++) begin last_prod[i] = '1; resp_cnt[i] = 0; end

    repeat (3) cycle();
    reset = 1'b0;

    // 1: single op on port 0
    src_q[0].push_back({32'd3, 32'd5});
    drain("t1_drain");
    chk("t1_prod", last_prod[0] == 32'd15, last_prod[0], 15);

    // 2: all four valid right after reset -> order 0,1,2,3
    do_reset(2);
    eager = 1'b1;
    gnt_log.delete();
    src_q[0].push_back({32'd2, 32'd3});
    src_q[1].push_back({32'd4, 32'd5});
    src_q[2].push_back({32'd6, 32'd7});
    src_q[3].push_back({32'd8, 32'd9});
    drain("t2_drain");
    chk("t2_log_len", gnt_log.size() == 4, gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("t2_order", gnt_log[i] == i, gnt_log[i], i);
    chk("t2_p0", last_prod[0] == 32'd6,  last_prod[0], 6);
    chk("t2_p1", last_prod[1] == 32'd20, last_prod[1], 20);
    chk("t2_p2", last_prod[2] == 32'd42, last_prod[2], 42);
    chk("t2_p3", last_prod[3] == 32'd72, last_prod[3], 72);

    // 3: pointer wrap: serve port 2 (ptr->3), then ports 1 and 3 -> 3 first, ptr ends 2
    src_q[2].push_back({32'd1, 32'd1});
    drain("t3_drain_a");
    gnt_log.delete();
    src_q[1].push_back({32'd10, 32'd11});
    src_q[3].push_back({32'd12, 32'd13});
    drain("t3_drain_b");
    chk_log("t3_wrap", 3, 1);
    gnt_log.delete();
    src_q[0].push_back({32'd5, 32'd5});
    src_q[2].push_back({32'd6, 32'd6});
    drain("t3_drain_c");
    chk_log("t3_ptr2", 2, 0);

    // 4: response backpressure on port 2 for 10 cycles (ptr is 1 here)
    hold_lo[2] = 1'b1;
    gnt_log.delete();
    src_q[2].push_back({32'hFFFF_FFFF, 32'd2});
    src_q[0].push_back({32'd1, 32'd7});
    t = 0;
    while (!resp_val[2] && t < 200) begin cycle(); t++; end
    chk("t4_resp_seen", resp_val[2], resp_val, 4);
    held = 0;
    for (int k = 0; k < 10; k++) begin
      if (resp_val[2] && resp_msg[95:64] == 32'hFFFF_FFFE && req_rdy == '0) held++;
      cycle();
    end
    chk("t4_held_cycles", held == 10, held, 10);
    hold_lo[2] = 1'b0;
    drain("t4_drain");
    chk_log("t4_order", 2, 0);
    chk("t4_prod", last_prod[2] == 32'hFFFF_FFFE, last_prod[2], 32'hFFFF_FFFE);

    // 5: reset while port 1's op sits in the multiplier
    cnt1 = resp_cnt[1];
    src_q[1].push_back({32'd7, 32'd9});
    t = 0;
    while (!mul_out_rdy && t < 200) begin cycle(); t++; end
    chk("t5_reached_wait", mul_out_rdy, mul_out_rdy, 1);
    do_reset(2);
    gnt_log.delete();
    src_q[0].push_back({32'd4, 32'd4});
    src_q[3].push_back({32'd1, 32'd2});
    drain("t5_drain");
    chk_log("t5_order", 0, 3);
    chk("t5_prod", last_prod[0] == 32'd16, last_prod[0], 16);
    chk("t5_no_stale_resp", resp_cnt[1] == cnt1, resp_cnt[1], cnt1);

    // 6: zero operand
    src_q[1].push_back({32'd0, 32'd12345});
    drain("t6_drain");
    chk("t6_prod", last_prod[1] == 32'd0, last_prod[1], 0);

    // random traffic with random delays and ready
    eager = 1'b0;
    for (int k = 0; k < 150; k++) begin
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      src_q[$urandom_range(0, N - 1)].push_back({a, b});
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
